// File: rtl/piso8_sequencer.sv
// piso8_sequencer: accepts an 8-bit word on a valid/ready handshake, then
// serialises it one bit per clock through an internal mux8 cell whose
// selects are driven from a 3-bit bit counter.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame in flight; load_ready=1, ser_out at IDLE_LEVEL
// SHIFT | emitting hold[cnt]; frame_last on the final bit, where a new
//       | word may be taken with no idle gap

// mux8 cell: y = i[j0*4 + j1*2 + j2]
module mux8 (
    input  logic [0:7] i,
    input  logic       j2,
    input  logic       j1,
    input  logic       j0,
    output logic       y
);

    // Select the addressed input bit
    always_comb begin
        y = i[{j0, j1, j2}];
    end

endmodule

module piso8_sequencer #(
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [0:7] load_data,
    output logic       sel_j2,
    output logic       sel_j1,
    output logic       sel_j0,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       frame_last,
    output logic [7:0] frame_count
);

    localparam logic [2:0] CNT_START = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] CNT_END   = MSB_FIRST ? 3'd0 : 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [0:7] hold_q;
    logic [2:0] cnt_q;
    logic [7:0] frame_count_q;
    logic       xfer;
    logic       mux_y;

    // mux8 selects come straight from the bit counter, so index == cnt
    assign sel_j2 = cnt_q[0];
    assign sel_j1 = cnt_q[1];
    assign sel_j0 = cnt_q[2];

    mux8 u_mux8 (
        .i  (hold_q),
        .j2 (sel_j2),
        .j1 (sel_j1),
        .j0 (sel_j0),
        .y  (mux_y)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/serial outputs
    always_comb begin
        state_d    = state_q;
        ser_valid  = 1'b0;
        frame_last = 1'b0;
        load_ready = 1'b1;
        xfer       = 1'b0;
        case (state_q)
            IDLE: begin
                xfer = load_valid;
                if (xfer) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid  = 1'b1;
                frame_last = (cnt_q == CNT_END);
                load_ready = frame_last;
                xfer       = load_valid & frame_last;
                // a word taken on the last bit keeps us in SHIFT with no gap
                if (frame_last && !xfer) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ser_out = ser_valid ? mux_y : IDLE_LEVEL;
    end

    // Word holding register, bit counter and completed-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q        <= '0;
            cnt_q         <= CNT_START;
            frame_count_q <= '0;
        end else begin
            if (xfer) begin
                hold_q <= load_data;
                cnt_q  <= CNT_START;
            end else if (frame_last) begin
                cnt_q  <= CNT_START;
            end else if (ser_valid) begin
                cnt_q  <= MSB_FIRST ? (cnt_q - 3'd1) : (cnt_q + 3'd1);
            end
            if (frame_last) begin
                frame_count_q <= frame_count_q + 8'd1;
            end
        end
    end

    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_piso8_sequencer.sv
// Testbench for piso8_sequencer: an LSB-first and an MSB-first instance share
// stimulus; a reference model pushes expected bits into a scoreboard queue
// and a negedge monitor pops and compares.
module tb_piso8_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic [0:7] load_data = '0;

    logic       a_load_ready, a_sel_j2, a_sel_j1, a_sel_j0;
    logic       a_ser_out, a_ser_valid, a_frame_last;
    logic [7:0] a_frame_count;
    logic       b_load_ready, b_sel_j2, b_sel_j1, b_sel_j0;
    logic       b_ser_out, b_ser_valid, b_frame_last;
    logic [7:0] b_frame_count;

    piso8_sequencer #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(a_load_ready),
        .load_data(load_data), .sel_j2(a_sel_j2), .sel_j1(a_sel_j1), .sel_j0(a_sel_j0),
        .ser_out(a_ser_out), .ser_valid(a_ser_valid), .frame_last(a_frame_last),
        .frame_count(a_frame_count)
    );

    piso8_sequencer #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(b_load_ready),
        .load_data(load_data), .sel_j2(b_sel_j2), .sel_j1(b_sel_j1), .sel_j0(b_sel_j0),
        .ser_out(b_ser_out), .ser_valid(b_ser_valid), .frame_last(b_frame_last),
        .frame_count(b_frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       a_bit;
        logic [2:0] a_idx;
        logic       b_bit;
        logic [2:0] b_idx;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    int         rem = 0;
    logic [7:0] exp_fc = 8'd0;
    int         checks = 0;
    int         errors = 0;
    int         timeouts = 0;
    int         timeouts_seen = 0;

    // Reference model: a frame is 8 bit-slots; a word is taken whenever at
    // most one slot of the current frame remains.
    always @(posedge clk or negedge rst_n) begin : model
        bit acc;
        if (!rst_n) begin
            rem    = 0;
            exp_fc = 8'd0;
            sb.delete();
        end else begin
            acc = load_valid && (rem <= 1);
            if (rem == 1) exp_fc = exp_fc + 8'd1;
            if (acc) begin
                rem = 8;
                for (int k = 0; k < 8; k++) begin
                    exp_t e;
                    e.a_bit = load_data[k];
                    e.a_idx = 3'(k);
                    e.b_bit = load_data[7-k];
                    e.b_idx = 3'(7 - k);
                    e.last  = (k == 7);
                    sb.push_back(e);
                end
            end else if (rem > 0) begin
                rem = rem - 1;
            end
        end
    end

    // Monitor: compare both instances against the model each cycle
    always @(negedge clk) begin : monitor
        exp_t e;
        if (timeouts != timeouts_seen) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: load_ready never rose (count %0d, required 0)", timeouts);
            timeouts_seen = timeouts;
        end
        if (!rst_n) begin
            checks++;
            if (a_ser_valid !== 1'b0 || b_ser_valid !== 1'b0 || a_frame_last !== 1'b0 ||
                b_frame_last !== 1'b0 || a_ser_out !== 1'b1 || b_ser_out !== 1'b1 ||
                a_load_ready !== 1'b1 || b_load_ready !== 1'b1 ||
                a_frame_count !== 8'd0 || b_frame_count !== 8'd0) begin
                errors++;
                $display("FAIL reset_outputs: got v=%b/%b last=%b/%b out=%b/%b rdy=%b/%b fc=%0d/%0d, required v=0 last=0 out=1 rdy=1 fc=0",
                         a_ser_valid, b_ser_valid, a_frame_last, b_frame_last, a_ser_out, b_ser_out,
                         a_load_ready, b_load_ready, a_frame_count, b_frame_count);
            end
        end else begin
            checks++;
            if (a_load_ready !== (rem <= 1) || b_load_ready !== (rem <= 1)) begin
                errors++;
                $display("FAIL load_ready: got %b/%b, required %b", a_load_ready, b_load_ready, (rem <= 1));
            end
            checks++;
            if (a_frame_count !== exp_fc || b_frame_count !== exp_fc) begin
                errors++;
                $display("FAIL frame_count: got %0d/%0d, required %0d", a_frame_count, b_frame_count, exp_fc);
            end
            checks++;
            if (a_ser_valid !== (sb.size() != 0) || b_ser_valid !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL ser_valid: got %b/%b, required %b", a_ser_valid, b_ser_valid, (sb.size() != 0));
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (a_ser_out !== e.a_bit || {a_sel_j0, a_sel_j1, a_sel_j2} !== e.a_idx ||
                    a_frame_last !== e.last) begin
                    errors++;
                    $display("FAIL lsb_first_bit: got out=%b idx=%0d last=%b, required out=%b idx=%0d last=%b",
                             a_ser_out, {a_sel_j0, a_sel_j1, a_sel_j2}, a_frame_last, e.a_bit, e.a_idx, e.last);
                end
                checks++;
                if (b_ser_out !== e.b_bit || {b_sel_j0, b_sel_j1, b_sel_j2} !== e.b_idx ||
                    b_frame_last !== e.last) begin
                    errors++;
                    $display("FAIL msb_first_bit: got out=%b idx=%0d last=%b, required out=%b idx=%0d last=%b",
                             b_ser_out, {b_sel_j0, b_sel_j1, b_sel_j2}, b_frame_last, e.b_bit, e.b_idx, e.last);
                end
            end else begin
                checks++;
                if (a_ser_out !== 1'b1 || b_ser_out !== 1'b1 || a_frame_last !== 1'b0 || b_frame_last !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs: got out=%b/%b last=%b/%b, required out=1 last=0",
                             a_ser_out, b_ser_out, a_frame_last, b_frame_last);
                end
            end
        end
    end

    // Offer a word and wait for the handshake; called just after a rising edge
    task automatic send(input logic [0:7] w, input bit keep);
        int n;
        n = 0;
        load_valid = 1'b1;
        load_data  = w;
        @(negedge clk);
        while (!a_load_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) timeouts++;
        @(posedge clk);
        #1;
        if (!keep) load_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit keep;
        // power-on reset, then idle cycles
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);

        // short reset pulse during bit 3 of a frame aborts it
        send(8'($urandom), 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        idle(3);
        send(8'($urandom), 1'b0);
        idle(10);

        // single frames with fixed patterns
        send(8'b1011_0010, 1'b0);
        idle(10);
        send(8'b1000_0001, 1'b0);
        idle(10);

        // back-to-back with load_valid held
        send(8'hFF, 1'b1);
        send(8'h00, 1'b0);
        idle(18);

        // randomized words, holds and gaps
        for (int i = 0; i < 30; i++) begin
            keep = 1'($urandom_range(0, 1));
            send(8'($urandom), keep);
            if (!keep) idle($urandom_range(0, 3));
        end
        load_valid = 1'b0;
        idle(12);

        // mid-simulation reset, then 256 continuous frames for frame_count wrap
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        for (int i = 0; i < 256; i++) begin
            send(8'($urandom), i != 255);
        end
        idle(12);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
